shift_reg_ctrl: RTL and testbench

SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

---
 rtl/shift_reg_ctrl_if.sv | 24 ++
 rtl/shift_reg_ctrl.sv | 156 +++++++++++++++
 tb/tb_shift_reg_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_ctrl_if.sv
// Command/response handshake bundle between a requester and shift_reg_ctrl.
// CNT_W must match the controller's CNT_W.
interface shift_reg_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [3:0]       cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/shift_reg_ctrl.sv
// Sequencer for a 4-bit universal shift register (load / hold / shift-up / shift-down).
// Define SHIFT_REG_CTRL_CMD_QUEUE_EN to add a 2-entry command FIFO ahead of the FSM.
module shift_reg_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic               CLK,
  input  logic               RSTn,
  shift_reg_ctrl_if.slave    bus,
  output logic               S1,
  output logic               S0,
  output logic [3:0]         D,
  input  logic [3:0]         Q,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESP} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       data;
  } cmd_t;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_LOAD_SHD = 2'b10;
  localparam logic [1:0] OP_SHU      = 2'b11;

  state_t           state_q, state_d;
  cmd_t             cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cmd_t in_cmd;
  cmd_t start_cmd;
  logic accept;
  logic start;
  logic queue_nonempty;

  assign in_cmd = {bus.cmd_op, bus.cmd_cnt, bus.cmd_data};
  assign accept = bus.cmd_valid & bus.cmd_ready;

`ifdef SHIFT_REG_CTRL_CMD_QUEUE_EN
  cmd_t       fifo_mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] fifo_cnt;
  logic       bypass, push, pop;

  // An arriving command with an empty FIFO and an idle FSM starts directly,
  // so queueing never adds latency to an isolated command.
  assign bus.cmd_ready  = RSTn & (fifo_cnt != 2'd2);
  assign bypass         = accept & (state_q == IDLE) & (fifo_cnt == 2'd0);
  assign push           = accept & ~bypass;
  assign pop            = (state_q == IDLE) & (fifo_cnt != 2'd0);
  assign start          = bypass | pop;
  assign start_cmd      = pop ? fifo_mem[rd_ptr] : in_cmd;
  assign queue_nonempty = (fifo_cnt != 2'd0);

  // NOTE: payload storage carries no reset; validity lives in the reset pointers/count.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 2'd1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 2'd1;
    end
  end
`else
  // Ready is gated by RSTn so nothing is offered while reset is held.
  assign bus.cmd_ready  = RSTn & (state_q == IDLE);
  assign start          = accept;
  assign start_cmd      = in_cmd;
  assign queue_nonempty = 1'b0;
`endif

  // NOTE: asynchronous reset in the sensitivity list; state uses non-blocking assignment only.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    cnt_d         = cnt_q;
    S1            = 1'b1;
    S0            = 1'b0;
    D             = 4'd0;
    bus.rsp_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_d = start_cmd;
          if (start_cmd.op != OP_SHU) begin
            state_d = LOAD;
          end else if (start_cmd.cnt == '0) begin
            state_d = RESP;
          end else begin
            state_d = SHIFT;
            cnt_d   = start_cmd.cnt;
          end
        end
      end

      LOAD: begin
        S0 = 1'b1;
        D  = cur_q.data;
        // A plain load ignores its count field entirely.
        if (cur_q.op != OP_LOAD && cur_q.cnt != '0) begin
          state_d = SHIFT;
          cnt_d   = cur_q.cnt;
        end else begin
          state_d = RESP;
        end
      end

      SHIFT: begin
        S1 = 1'b0;
        S0 = (cur_q.op == OP_LOAD_SHD);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // The register holds while in RESP, so passing Q straight through stays stable.
  assign bus.rsp_data = Q;
  assign busy         = (state_q != IDLE) | queue_nonempty;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Scoreboard bench for shift_reg_ctrl: randomized commands against an arithmetic
// model of the register result, plus directed load/shift/backpressure/reset cases.
module tb_shift_reg_ctrl;
  localparam int CNT_W = 3;

  logic       CLK  = 1'b0;
  logic       RSTn = 1'b0;
  logic       S1, S0, busy;
  logic [3:0] D, Q;
  logic [3:0] reg_q = 4'd0;

  shift_reg_ctrl_if #(.CNT_W(CNT_W)) bus ();

  shift_reg_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.slave),
    .S1   (S1),
    .S0   (S0),
    .D    (D),
    .Q    (Q),
    .busy (busy)
  );

  always #5 CLK = ~CLK;

  // Ideal external register with zero serial inputs.
  always @(posedge CLK) begin
    case ({S1, S0})
      2'b11:   reg_q <= D;
      2'b00:   reg_q <= {reg_q[2:0], 1'b0};
      2'b01:   reg_q <= {1'b0, reg_q[3:1]};
      default: reg_q <= reg_q;
    endcase
  end
  assign Q = reg_q;

  typedef struct {
    logic [3:0] data;
    logic [3:0] ld_data;
    int         load;
    int         nshift;
    int         accept_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic       force_low = 1'b0;
  logic [3:0] model_reg = 4'd0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Offer one command, wait for acceptance, and record what the response must be.
  task automatic send(input logic [1:0] op, input int cnt, input logic [3:0] data);
    exp_t e;
    int   waited = 0;
    int   wide;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_cnt   = cnt[CNT_W-1:0];
    bus.cmd_data  = data;
    while (!bus.cmd_ready && waited < 500) begin
      @(negedge CLK);
      waited++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_accept_timeout", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    e.accept_cyc = cyc;
    e.ld_data    = data;
    e.load       = (op != 2'b11) ? 1 : 0;
    e.nshift     = (op == 2'b00) ? 0 : cnt;
    case (op)
      2'b00: e.data = data;
      2'b01: begin wide = int'(data) << cnt;      e.data = wide[3:0]; end
      2'b10: begin wide = int'(data) >> cnt;      e.data = wide[3:0]; end
      default: begin wide = int'(model_reg) << cnt; e.data = wide[3:0]; end
    endcase
    model_reg = e.data;
    exp_q.push_back(e);
    @(negedge CLK);
    // Scramble inputs after acceptance; the command must already be latched.
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_cnt   = CNT_W'($urandom);
    bus.cmd_data  = 4'($urandom);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < 300) begin
      @(negedge CLK);
      w++;
    end
    check("idle_timeout", busy, 0);
  endtask

  // Response acceptor: random backpressure unless a directed test forces it low.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge CLK);
      bus.rsp_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: counts select activity per command and checks each response.
  initial begin
    int         n_ld = 0;
    int         n_sh = 0;
    logic       in_rsp = 1'b0;
    logic [3:0] held = 4'd0;
    logic [3:0] last_d = 4'd0;
    exp_t       e;
    forever begin
      @(negedge CLK);
      #1;
      if (!RSTn) begin
        n_ld = 0; n_sh = 0; in_rsp = 1'b0;
        continue;
      end
      if (!in_rsp) begin
        if ({S1, S0} == 2'b11) begin
          n_ld++;
          last_d = D;
        end else if (!S1) begin
          n_sh++;
        end
      end else begin
        check("rsp_valid_hold", bus.rsp_valid, 1);
      end
      if (bus.rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          held   = bus.rsp_data;
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", bus.rsp_data, e.data);
            check("load_cycles", n_ld, e.load);
            check("shift_cycles", n_sh, e.nshift);
            if (e.load != 0) check("load_value", last_d, e.ld_data);
`ifndef SHIFT_REG_CTRL_CMD_QUEUE_EN
            check("rsp_latency", cyc, e.accept_cyc + 1 + e.load + e.nshift);
`endif
          end
        end else begin
          check("rsp_data_hold", bus.rsp_data, held);
        end
        if (bus.rsp_ready) begin
          in_rsp = 1'b0; n_ld = 0; n_sh = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_cnt   = '0;
    bus.cmd_data  = 4'd0;

    repeat (3) @(negedge CLK);
    check("rst_sel",       {S1, S0}, 2'b10);
    check("rst_d",         D, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_busy",      busy, 0);
    RSTn = 1'b1;
    @(negedge CLK);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);

    // Load-only: count field must be ignored.
    send(2'b00, 5, 4'b1010);
    check("load_sel", {S1, S0}, 2'b11);
    check("load_d",   D, 4'b1010);
    check("load_busy", busy, 1);
    wait_idle();

    // Load then shift up three times.
    send(2'b01, 3, 4'b0001);
    check("lsu_load_sel", {S1, S0}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("lsu_shift_sel", {S1, S0}, 2'b00);
    end
    @(negedge CLK);
    check("lsu_rsp_valid", bus.rsp_valid, 1);
    wait_idle();

    // Shift-only with N=0 goes straight to the response.
    send(2'b11, 0, 4'b0111);
    check("n0_rsp_valid", bus.rsp_valid, 1);
    check("n0_sel", {S1, S0}, 2'b10);
    wait_idle();

    // Backpressure: response held for four cycles.
    force_low = 1'b1;
    send(2'b10, 2, 4'b1100);
    w = 0;
    while (!bus.rsp_valid && w < 50) begin
      @(negedge CLK);
      w++;
    end
    check("bp_rsp_seen", bus.rsp_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_sel", {S1, S0}, 2'b10);
      check("bp_d", D, 0);
`ifndef SHIFT_REG_CTRL_CMD_QUEUE_EN
      check("bp_cmd_ready", bus.cmd_ready, 0);
`endif
    end
    force_low = 1'b0;
    wait_idle();

    // Reset during the second shift cycle of N=5 aborts without a response.
    send(2'b01, 5, 4'b0011);
    @(negedge CLK);
    @(negedge CLK);
    check("abort_in_shift", {S1, S0}, 2'b00);
    RSTn = 1'b0;
    #1;
    check("abort_sel",       {S1, S0}, 2'b10);
    check("abort_d",         D, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_busy",      busy, 0);
    check("abort_cmd_ready", bus.cmd_ready, 0);
    exp_q.delete();
    bus.cmd_valid = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_hold_cmd_ready", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    RSTn = 1'b1;
    repeat (12) @(negedge CLK);
    check("abort_no_rsp", bus.rsp_valid, 0);
    check("abort_idle",   busy, 0);
    send(2'b00, 0, 4'b0110);
    wait_idle();

`ifdef SHIFT_REG_CTRL_CMD_QUEUE_EN
    // Three back-to-back commands fill the queue behind the active one.
    force_low = 1'b1;
    send(2'b00, 0, 4'b0101);
    send(2'b01, 1, 4'b0011);
    send(2'b10, 2, 4'b1000);
    check("q_full_cmd_ready", bus.cmd_ready, 0);
    check("q_busy", busy, 1);
    force_low = 1'b0;
    wait_idle();
`endif

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      send(2'($urandom_range(0, 3)), $urandom_range(0, (1 << CNT_W) - 1), 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    wait_idle();
    check("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
